// File: rtl/bcd_display.sv
// bcd_display: 8-bit binary to 3-digit BCD converter (shift-and-add-3)
// driving a time-multiplexed 4-digit active-low seven-segment display.
module bcd_display #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  bin_in,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic [3:0]  an
);

   localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [19:0]   r_shift;
   logic [19:0]   w_adj;
   logic [19:0]   w_shifted;
   logic [2:0]    r_cnt;
   logic [11:0]   r_bcd;
   logic [CW-1:0] r_scan;
   logic [1:0]    r_idx;
   logic [6:0]    r_seg;
   logic [3:0]    r_an;
   logic [6:0]    w_seg_next;
   logic [3:0]    w_an_next;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; load only matters in IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (load) w_next = ST_SHIFT;
         ST_SHIFT: if (r_cnt == 3'd7) w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Add 3 to every BCD field >= 5 before the shift
   always_comb begin
      w_adj = r_shift;
      for (int unsigned i = 0; i < 3; i++) begin
         if (r_shift[8 + 4*i +: 4] >= 4'd5)
            w_adj[8 + 4*i +: 4] = r_shift[8 + 4*i +: 4] + 4'd3;
      end
      w_shifted = {w_adj[18:0], 1'b0};
   end

   // Converter datapath: shift register, iteration count, result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_shift <= {12'b0, bin_in};
                  r_cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               r_shift <= w_shifted;
               r_cnt   <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) r_bcd <= w_shifted[19:8];
            end
            default: ;
         endcase
      end
   end

   // Scan divider and digit index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan <= '0;
         r_idx  <= '0;
      end else if (r_scan == CW'(SCAN_DIV - 1)) begin
         r_scan <= '0;
         r_idx  <= r_idx + 2'd1;
      end else begin
         r_scan <= r_scan + CW'(1);
      end
   end

   // Digit select with leading-zero blanking, from the registered result only
   always_comb begin
      w_seg_next = SEG_BLANK;
      w_an_next  = ~(4'b0001 << r_idx);
      case (r_idx)
         2'd0: w_seg_next = seg_code(r_bcd[3:0]);
         2'd1: if (r_bcd[11:4] != 8'd0) w_seg_next = seg_code(r_bcd[7:4]);
         2'd2: if (r_bcd[11:8] != 4'd0) w_seg_next = seg_code(r_bcd[11:8]);
         default: w_seg_next = SEG_BLANK;
      endcase
   end

   // Registered display outputs, one cycle behind the index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg <= 7'b1000000;
         r_an  <= 4'b1110;
      end else begin
         r_seg <= w_seg_next;
         r_an  <= w_an_next;
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = (r_state == ST_DONE);
   assign bcd  = r_bcd;
   assign seg  = r_seg;
   assign an   = r_an;

endmodule
